// File: rtl/wb_sram_slave_if.sv
// rtl/wb_sram_slave_if.sv - Pipelined Wishbone B4 bus bundle between master and the SRAM responder.
interface wb_sram_slave_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0]   wb_adr_i;
    logic [DWIDTH-1:0]   wb_dat_i;
    logic [DWIDTH/8-1:0] wb_sel_i;
    logic                wb_we_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic [DWIDTH-1:0]   wb_dat_o;
    logic                wb_stall_o;
    logic                wb_ack_o;
    logic                wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_stall_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_stall_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Pipelined Wishbone SRAM responder, fixed RD_LAT response latency.
// Define WB_SRAM_OOR_ERR_EN to terminate out-of-window requests with err instead of wrapping.
module wb_sram_slave #(
    parameter int              AWIDTH      = 32,
    parameter int              DWIDTH      = 32,
    parameter int              DEPTH_WORDS = 256,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0000_0400,
    parameter int              RD_LAT      = 2,
    parameter int              MAX_OUTST   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_sram_slave_if.slave   wb
);
    localparam int          IDXW  = $clog2(DEPTH_WORDS);
    localparam int          SELW  = DWIDTH / 8;
    localparam logic [2:0]  MAX_Q = 3'(MAX_OUTST);

    logic [DWIDTH-1:0] mem [DEPTH_WORDS];

    logic [RD_LAT:1]   vld_q, vld_d;
    logic [RD_LAT:1]   err_q, err_d;
    logic [DWIDTH-1:0] dat_q [1:RD_LAT];
    logic [DWIDTH-1:0] dat_d [1:RD_LAT];
    logic [2:0]        outst_q, outst_d;

    logic              retire;
    logic              accept;
    logic              misaligned;
    logic              req_err;
    logic              wr_en;
    logic [IDXW-1:0]   idx;

    assign retire        = vld_q[RD_LAT];
    assign wb.wb_stall_o = (outst_q == MAX_Q) & ~retire;
    assign accept        = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_stall_o;
    assign misaligned    = wb.wb_adr_i[1:0] != 2'b00;

`ifdef WB_SRAM_OOR_ERR_EN
    logic [AWIDTH-1:0] off;
    logic              hit;
    assign off     = wb.wb_adr_i - BASE_ADDR;
    assign hit     = (wb.wb_adr_i >= BASE_ADDR) && (off < AWIDTH'(DEPTH_WORDS * 4));
    assign idx     = off[IDXW+1:2];
    assign req_err = misaligned | ~hit;
`else
    // Only the low offset bits matter when the window wraps modulo its size.
    logic [IDXW+1:0] off_lo;
    assign off_lo  = wb.wb_adr_i[IDXW+1:0] - BASE_ADDR[IDXW+1:0];
    assign idx     = off_lo[IDXW+1:2];
    assign req_err = misaligned;
`endif

    assign wr_en = accept & wb.wb_we_i & ~req_err;

    always_comb begin
        vld_d   = vld_q;
        err_d   = err_q;
        dat_d   = dat_q;
        outst_d = outst_q;
        if (!wb.wb_cyc_i) begin
            vld_d   = '0;
            outst_d = '0;
        end else begin
            vld_d[1] = accept;
            err_d[1] = accept & req_err;
            dat_d[1] = (accept & ~wb.wb_we_i & ~req_err) ? mem[idx] : '0;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                err_d[k] = err_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
            outst_d = outst_q + {2'b00, accept} - {2'b00, retire};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            err_q   <= '0;
            outst_q <= '0;
            for (int k = 1; k <= RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            err_q   <= err_d;
            outst_q <= outst_d;
            for (int k = 1; k <= RD_LAT; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // RAM contents survive reset; only the write strobe is held off.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < SELW; b++) begin
                if (wb.wb_sel_i[b]) begin
                    mem[idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_ack_o = wb.wb_cyc_i & retire & ~err_q[RD_LAT];
    assign wb.wb_err_o = wb.wb_cyc_i & retire & err_q[RD_LAT];
    assign wb.wb_dat_o = wb.wb_ack_o ? dat_q[RD_LAT] : '0;
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - Self-checking bench for wb_sram_slave, vector table plus scoreboard.
module tb_wb_sram_slave;
    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cnt   = 0;
    int   total = 0;
    int   bad   = 0;
    int   resp_a = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    wb_sram_slave_if #(.AWIDTH(32), .DWIDTH(32)) bus_a ();
    wb_sram_slave_if #(.AWIDTH(32), .DWIDTH(32)) bus_b ();

    wb_sram_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0400),
                    .RD_LAT(RD_LAT), .MAX_OUTST(2)) dut_a (.clk(clk), .rst_n(rst_n), .wb(bus_a.slave));
    wb_sram_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0400),
                    .RD_LAT(RD_LAT), .MAX_OUTST(1)) dut_b (.clk(clk), .rst_n(rst_n), .wb(bus_b.slave));

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          b_cyc[$];
    logic [31:0] b_dat[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cnt) begin
            total++;
            bad++;
            $display("FAIL missing_resp: due cycle %0d, still absent at %0d", sb[0].due, cnt);
            void'(sb.pop_front());
        end
        if (bus_a.wb_ack_o || bus_a.wb_err_o) begin
            resp_a++;
            chk("ack_err_excl", 32'(bus_a.wb_ack_o & bus_a.wb_err_o), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d expected none",
                         bus_a.wb_ack_o, bus_a.wb_err_o, cnt);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_err", 32'(bus_a.wb_err_o), 32'(mon_e.err));
                chk("resp_dat", bus_a.wb_dat_o, mon_e.dat);
                chk("resp_time", 32'(cnt), 32'(mon_e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.wb_ack_o) begin
            b_cyc.push_back(cnt);
            b_dat.push_back(bus_b.wb_dat_o);
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                         input bit push);
        int n = 0;
        bus_a.wb_cyc_i = 1'b1;
        bus_a.wb_stb_i = 1'b1;
        bus_a.wb_we_i  = we;
        bus_a.wb_adr_i = adr;
        bus_a.wb_dat_i = dat;
        bus_a.wb_sel_i = sel;
        while (bus_a.wb_stall_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: adr %h still stalled after %0d cycles, expected accept", adr, n);
        end else if (push) begin
            sb.push_back('{exp_err, exp_dat, cnt + RD_LAT});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bus_a.wb_stb_i = 1'b0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    vec_t vt[16];

    initial begin
        int r0;
        int n;
        int stalls;

        vt[0]  = '{1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0404, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_0408, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h0000_0408, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h0000_0408, 32'h0,         4'hF, 1'b0, 32'h11BB_33DD};
        vt[5]  = '{1'b0, 32'h0000_0402, 32'h0,         4'hF, 1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0405, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
        vt[7]  = '{1'b0, 32'h0000_0404, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        vt[8]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 32'h0000_0404, 32'h0,         4'h0, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h0000_0404, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        vt[11] = '{1'b1, 32'h0000_07FC, 32'h0A0B_0C0D, 4'hF, 1'b0, 32'h0};
        vt[12] = '{1'b0, 32'h0000_07FC, 32'h0,         4'hF, 1'b0, 32'h0A0B_0C0D};
`ifdef WB_SRAM_OOR_ERR_EN
        vt[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 32'h0};
        vt[14] = '{1'b0, 32'h0000_0800, 32'h0,         4'hF, 1'b1, 32'h0};
        vt[15] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 1'b1, 32'h0};
`else
        vt[13] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
        vt[14] = '{1'b0, 32'h0000_0800, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
        vt[15] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 1'b0, 32'h0A0B_0C0D};
`endif

        bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0; bus_a.wb_we_i = 1'b0;
        bus_a.wb_adr_i = '0;   bus_a.wb_dat_i = '0;   bus_a.wb_sel_i = '0;
        bus_b.wb_cyc_i = 1'b0; bus_b.wb_stb_i = 1'b0; bus_b.wb_we_i = 1'b0;
        bus_b.wb_adr_i = '0;   bus_b.wb_dat_i = '0;   bus_b.wb_sel_i = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack",   32'(bus_a.wb_ack_o),   32'd0);
        chk("rst_err",   32'(bus_a.wb_err_o),   32'd0);
        chk("rst_stall", 32'(bus_a.wb_stall_o), 32'd0);
        chk("rst_dat",   bus_a.wb_dat_o,        32'd0);
        @(posedge clk);
        #1;

        // Vector table issued back to back, stb held high throughout.
        for (int i = 0; i < 16; i++) begin
            issue(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].err, vt[i].rdat, 1'b1);
        end
        drain();

        // Cycle abort with two reads in flight.
        issue(1'b0, 32'h0000_0404, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h0000_0408, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
        r0 = resp_a;
        bus_a.wb_cyc_i = 1'b0;
        bus_a.wb_stb_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(resp_a - r0), 32'd0);
        chk("abort_stall",   32'(bus_a.wb_stall_o), 32'd0);
        chk("abort_outst",   32'(dut_a.outst_q), 32'd0);
        issue(1'b0, 32'h0000_0404, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 32'h0000_0408, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD, 1'b1);
        drain();

        // Reset right after a write: its ack is lost, the data is not.
        issue(1'b1, 32'h0000_040C, 32'h600D_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
        r0 = resp_a;
        bus_a.wb_stb_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_no_resp", 32'(resp_a - r0), 32'd0);
        issue(1'b0, 32'h0000_040C, 32'h0, 4'hF, 1'b0, 32'h600D_F00D, 1'b1);
        drain();
        bus_a.wb_cyc_i = 1'b0;

        // MAX_OUTST=1 instance: 4 writes then 4 reads with stb held.
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            bus_b.wb_cyc_i = 1'b1;
            bus_b.wb_stb_i = 1'b1;
            bus_b.wb_we_i  = (i < 4);
            bus_b.wb_adr_i = 32'h0000_0400 + 32'(4 * (i % 4));
            bus_b.wb_dat_i = 32'hB000_0000 + 32'(i);
            bus_b.wb_sel_i = 4'hF;
            n = 0;
            while (bus_b.wb_stall_o && n < 20) begin
                stalls++;
                @(posedge clk);
                #1;
                n++;
            end
            @(posedge clk);
            #1;
        end
        bus_b.wb_stb_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus_b.wb_cyc_i = 1'b0;
        chk("b_ack_count", 32'(b_cyc.size()), 32'd8);
        chk("b_stall_cycles", 32'(stalls), 32'd7);
        if (b_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                chk("b_ack_spacing", 32'(b_cyc[i] - b_cyc[i-1]), 32'd2);
            end
            for (int i = 0; i < 4; i++) begin
                chk("b_wr_dat", b_dat[i], 32'd0);
                chk("b_rd_dat", b_dat[i+4], 32'hB000_0000 + 32'(i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Pipelined Wishbone B4 responder backed by a synchronous word-addressed RAM.
- Serves the slave side of the common interconnect alongside the boot ROM, as read/write data memory for the CPU cluster.
- Accepts one request per cycle and returns each ack/err exactly RD_LAT cycles after acceptance, in order.
- Limits in-flight requests with wb_stall_o.

Parameters:
- AWIDTH, 32, byte address width
- DWIDTH, 32, data width; must be 32
- DEPTH_WORDS, 256, RAM size in 32-bit words; power of two
- BASE_ADDR, 32'h0000_0400, byte base address of the RAM window
- RD_LAT, 2, cycles from acceptance to ack/err; legal range 1..4
- MAX_OUTST, 2, maximum requests in flight; legal range 1..RD_LAT

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wb_adr_i  in  AWIDTH  byte address
- wb_dat_i  in  DWIDTH  write data
- wb_sel_i  in  DWIDTH/8  byte enables
- wb_we_i  in  1  1 = write
- wb_cyc_i  in  1  bus cycle active
- wb_stb_i  in  1  request strobe
- wb_dat_o  out  DWIDTH  read data, valid only with wb_ack_o
- wb_stall_o  out  1  request not accepted this cycle
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low: rst_n sampled low at a clk rising edge resets the block.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_stall_o=0, wb_dat_o=0. Response pipeline valids and the outstanding counter clear to 0. RAM contents are not reset.
- Reset mid-operation: all in-flight responses are discarded and none is ever issued. Writes committed before reset remain in the RAM.
- Accept: wb_cyc_i & wb_stb_i & ~wb_stall_o at a rising edge.
- Stall: wb_stall_o = (outst == MAX_OUTST) & ~retire. It is combinational from registered state; retire is the pipeline's last stage being valid this cycle.
- Outstanding counter, outst:
  - +1 on accept, -1 on retire; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTST and never underflows.
- Decode at accept:
  - off = wb_adr_i - BASE_ADDR.
  - hit = (wb_adr_i >= BASE_ADDR) & (off < DEPTH_WORDS*4).
  - misaligned = wb_adr_i[1:0] != 0.
  - Word index = off[log2(DEPTH_WORDS)+1:2].
- Write (we=1, hit, aligned):
  - RAM is updated on the accept edge, only bytes with sel[i]=1.
  - sel=0 performs no update but is still acked.
- Read (we=0, hit, aligned): RAM read launched at accept. Data appears on wb_dat_o together with wb_ack_o RD_LAT cycles later.
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data. Only one request is accepted per cycle, so there is no same-cycle conflict.
- Error: a misaligned request raises wb_err_o instead of wb_ack_o, RD_LAT cycles after accept. It causes no RAM update and wb_dat_o=0.
- Out-of-range requests: see Optional Feature.
- Response pipeline: RD_LAT-deep shift register holding {valid, is_err, data}. Stage RD_LAT drives the outputs for exactly one cycle. wb_ack_o and wb_err_o are never both 1.
- wb_dat_o is 0 whenever wb_ack_o=0 or the retiring request was a write.
- Cycle abort: if wb_cyc_i=0 in any cycle, all pipeline valids are cleared on that edge and outst returns to 0. Responses for aborted requests are never issued; writes already committed remain.
- Back-to-back: with MAX_OUTST = RD_LAT, sustained throughput is one request per cycle with no stall.

Optional Feature:
- Macro: WB_SRAM_OOR_ERR_EN.
- Defined: a request with hit=0 terminates with wb_err_o after RD_LAT cycles, with no RAM access and wb_dat_o=0.
- Undefined: hit is ignored. The word index wraps modulo DEPTH_WORDS, and the access completes normally with wb_ack_o.
- Misaligned requests produce wb_err_o in both builds.

Test Plan:
- Reset release, idle bus -> ack, err, stall and dat_o all 0.
- Write 0xDEADBEEF to 0x404 with sel=4'hF, then read 0x404 the next cycle (RD_LAT=2) -> acks 2 cycles after each accept, read ack carries 0xDEADBEEF.
- Write 0x11223344 to 0x408, then write 0xAABBCCDD with sel=4'b0101, then read 0x408 -> 0x11BB33DD.
- MAX_OUTST=1, RD_LAT=2, stb held high with 4 reads -> stall high 1 of every 2 cycles; 4 acks in order, one every 2 cycles.
- Read from 0x402 -> err after 2 cycles, no ack.
- Read from 0x0000_0000:
  - with WB_SRAM_OOR_ERR_EN -> err;
  - without it -> ack with the contents of word 0.
- Accept 2 reads, drop cyc the next cycle -> no ack or err ever appears; outst=0 and stall=0 afterwards.
- Accept a write to 0x40C, assert rst_n low the next cycle -> no ack issued; a later read of 0x40C returns the written value.
